keccak_pad_blk: RTL and testbench
=================================

# keccak_pad_blk

Upstream feeder for the Keccak permutation stage. Accepts a message as a byte stream, packs bytes little-endian into 64-bit lanes, and applies SHA-3 pad10*1 padding with a domain-separation byte. Emits each 1600-bit block as 25 lanes, in order lane 0..24, on the permutation block's `pushin`/`stopin`/`firstin`/`din` interface. Capacity lanes are sent as zero.

## Interface
Parameters:
- `RATE_LANES`, default 17, number of rate lanes per block (17 = SHA3-256, 136 bytes); legal range 1..24.
- `DSBYTE`, default 8'h06, domain byte ORed in at the first pad position.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pushin`  in  1  input byte valid.
- `firstin`  in  1  qualifies the first byte of a message.
- `lastin`  in  1  qualifies the last byte of a message.
- `din`  in  8  message byte.
- `stopin`  out  1  backpressure to the source; the byte is not accepted while high.
- `pushout`  out  1  lane valid to the permutation block.
- `firstout`  out  1  high with lane 0 of every block.
- `dout`  out  64  lane data.
- `stopout`  in  1  backpressure from the permutation block.
- `err`  out  1  sticky protocol error; see Configuration.

## Operation
- Input transfer: `pushin && !stopin`. Output transfer: `pushout && !stopout`.
- While `pushout && stopout`, `pushout`, `firstout` and `dout` hold stable.
- Datapath:
  - lane assembly register `asm[63:0]` with byte index `bi` (0..7);
  - single-entry output register;
  - lane counter `ln` (0..24).
- Byte packing: byte at `bi = k` lands in `asm[8k+7:8k]`.
- Messages are at least 1 byte long. `firstin && lastin` on the same byte is a 1-byte message.
- States:
  - IDLE: wait for a byte with `firstin`. Bytes without `firstin` are dropped.
  - ABSORB: accept bytes.
    - When `bi = 7`, move `asm` to the output register.
    - After rate lane `RATE_LANES-1` completes, go to CAP.
    - On the `lastin` byte, go to PAD.
  - PAD: `stopin` is high. Generate padding bytes at one byte per cycle, into the same lane/byte positions.
    - The first pad byte is `DSBYTE`.
    - Following bytes are 0x00.
    - The last byte of the rate (byte `8*RATE_LANES-1`) is ORed with 0x80.
    - If the first pad position is the last rate byte, that byte is `DSBYTE|0x80` (0x86).
    - If the message ends exactly at a rate boundary, CAP runs first. The padding then fills an entire new block, with `firstout` on its lane 0.
    - After the rate completes, go to CAP with a final flag set.
  - CAP: `stopin` is high. Emit lanes `RATE_LANES`..24 as 64'h0, one lane per output transfer.
    - After lane 24, go to IDLE if the final flag is set; otherwise go to ABSORB.
- `firstout` is 1 exactly when the emitted lane has `ln = 0`.
- `stopin = 1` in the following cases:
  - in PAD or CAP;
  - after reset until the first clock edge with `rst` high;
  - when `bi = 7` and the output register is full and not draining this cycle.

## Timing
- Reset (`rst` low, asynchronous) puts the block in this state:
  - state IDLE;
  - `bi = 0`, `ln = 0`, `asm = 0`;
  - output register empty;
  - `pushout = 0`, `firstout = 0`, `dout = 64'h0`;
  - `stopin = 1`;
  - `err = 0`.
- Reset mid-block discards all partial data. No lane is emitted after deassertion until a new `firstin` byte arrives.
- Lane latency: `pushout` rises on the cycle after the edge that accepts its 8th byte.
- Throughput: one byte per cycle sustained with `stopout = 0`.
- The output register loads on the same edge that drains it (no bubble).
- CAP lanes load one per cycle when not stalled.
- Per block with no stalls: block output time = 8×RATE_LANES byte cycles + 1 + (25−RATE_LANES) lane cycles.
- Simultaneous drain and load: drain takes effect first, and the new lane is captured.

## Configuration
- `KECCAK_PAD_PROTO_CHECK_EN`:
  - Defined: `err` sets (sticky until reset) on either of these events:
    - an accepted byte with `firstin` while in ABSORB;
    - a byte with no `firstin` presented in IDLE.
  - Not defined: `err` is tied to 0 and the check logic is absent.
- Data behaviour is identical either way.

## Test plan
- 1-byte message 0x61 (`firstin`=`lastin`=1), `stopout`=0:
  - 25 lanes out;
  - lane0 = 64'h0000_0000_0000_0661 with `firstout`=1;
  - lane16 = 64'h8000_0000_0000_0000;
  - all other lanes 0.
- 135-byte message of 0x00: lane16 = 64'h8600_0000_0000_0000; 25 lanes total.
- 136-byte message of 0xFF:
  - 50 lanes total;
  - lanes 0–16 = all-ones;
  - lane 25 (new block) = 64'h06 with `firstout`=1;
  - lane 41 = 64'h8000_0000_0000_0000.
- Hold `stopout`=1 for 10 cycles after the first `pushout`:
  - `dout`/`firstout` stable;
  - `stopin` rises once the next lane completes;
  - no byte lost;
  - lane sequence unchanged.
- Assert `rst` low mid-lane (byte 3 of lane 5), then send a 1-byte message: output matches the first scenario exactly.
- With `KECCAK_PAD_PROTO_CHECK_EN`: a `firstin` byte in mid-message sets `err`=1, and `err` stays 1 until reset.

Source files
------------

// File: rtl/keccak_pad_blk.sv
// rtl/keccak_pad_blk.sv - byte-stream lane packer with SHA-3 pad10*1, emits 25-lane Keccak blocks
// Optional macro KECCAK_PAD_PROTO_CHECK_EN enables the sticky err protocol check.
module keccak_pad_blk #(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DSBYTE     = 8'h06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic        firstin,
  input  logic        lastin,
  input  logic [7:0]  din,
  output logic        stopin,
  output logic        pushout,
  output logic        firstout,
  output logic [63:0] dout,
  input  logic        stopout,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ABSORB, PAD, CAP} state_t;

  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] LAST_LANE = 5'd24;

  state_t      state, state_nx;
  logic [63:0] asm_q, asm_nx;
  logic [2:0]  bi;
  logic [4:0]  ln;
  logic        live;
  logic        final_q, final_nx;
  logic        padpend_q, padpend_nx;
  logic        padfirst_q;
  logic        drain, can_load, acc, take, pad_wr, wr, lane_done, cap_ld;
  logic [7:0]  wbyte;

  always_comb begin
    drain      = pushout && !stopout;
    can_load   = !pushout || drain;
    stopin     = !live || (state == PAD) || (state == CAP) || ((bi == 3'd7) && !can_load);
    acc        = pushin && !stopin;
    take       = acc && ((state == ABSORB) || ((state == IDLE) && firstin));
    pad_wr     = (state == PAD) && ((bi != 3'd7) || can_load);
    wr         = take || pad_wr;
    // Pad byte: domain byte at the first pad slot, 0x80 OR-ed into the last rate byte.
    wbyte      = take ? din
               : ((padfirst_q ? DSBYTE : 8'h00) |
                  (((ln == LAST_RATE) && (bi == 3'd7)) ? 8'h80 : 8'h00));
    asm_nx     = asm_q | (64'(wbyte) << {bi, 3'b000});
    lane_done  = wr && (bi == 3'd7);
    cap_ld     = (state == CAP) && can_load;
    state_nx   = state;
    final_nx   = final_q;
    padpend_nx = padpend_q;
    case (state)
      IDLE, ABSORB: begin
        if (take) begin
          if (lane_done && (ln == LAST_RATE)) begin
            state_nx   = CAP;
            padpend_nx = lastin;
          end else if (lastin) begin
            state_nx = PAD;
          end else begin
            state_nx = ABSORB;
          end
        end
      end
      PAD: begin
        if (lane_done && (ln == LAST_RATE)) begin
          state_nx = CAP;
          final_nx = 1'b1;
        end
      end
      CAP: begin
        if (cap_ld && (ln == LAST_LANE)) begin
          if (final_q) begin
            state_nx   = IDLE;
            final_nx   = 1'b0;
            padpend_nx = 1'b0;
          end else if (padpend_q) begin
            state_nx   = PAD;
            padpend_nx = 1'b0;
          end else begin
            state_nx = ABSORB;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q      <= 64'h0;
      bi         <= 3'd0;
      ln         <= 5'd0;
      live       <= 1'b0;
      final_q    <= 1'b0;
      padpend_q  <= 1'b0;
      padfirst_q <= 1'b0;
      pushout    <= 1'b0;
      firstout   <= 1'b0;
      dout       <= 64'h0;
    end else begin
      live      <= 1'b1;
      final_q   <= final_nx;
      padpend_q <= padpend_nx;
      if ((state_nx == PAD) && (state != PAD)) padfirst_q <= 1'b1;
      else if (pad_wr)                         padfirst_q <= 1'b0;
      // Drain first; a load on the same edge overrides it.
      if (drain) pushout <= 1'b0;
      if (wr) begin
        if (bi == 3'd7) begin
          pushout  <= 1'b1;
          firstout <= (ln == 5'd0);
          dout     <= asm_nx;
          asm_q    <= 64'h0;
          bi       <= 3'd0;
          ln       <= ln + 5'd1;
        end else begin
          asm_q <= asm_nx;
          bi    <= bi + 3'd1;
        end
      end else if (cap_ld) begin
        pushout  <= 1'b1;
        firstout <= 1'b0;
        dout     <= 64'h0;
        ln       <= (ln == LAST_LANE) ? 5'd0 : ln + 5'd1;
      end
    end
  end

`ifdef KECCAK_PAD_PROTO_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((acc && firstin && (state == ABSORB)) ||
                 (pushin && !firstin && (state == IDLE))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_pad_blk.sv
// tb/tb_keccak_pad_blk.sv - scoreboard bench for keccak_pad_blk
module tb_keccak_pad_blk;

  logic        clk = 1'b0;
  logic        rst, pushin, firstin, lastin, stopout;
  logic [7:0]  din;
  logic        stopin, pushout, firstout, err;
  logic [63:0] dout;

  keccak_pad_blk dut (
    .clk(clk), .rst(rst), .pushin(pushin), .firstin(firstin), .lastin(lastin),
    .din(din), .stopin(stopin), .pushout(pushout), .firstout(firstout),
    .dout(dout), .stopout(stopout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic [63:0] d;
  } exp_t;

  exp_t        q[$];
  logic [63:0] stage[50];
  int          tests = 0;
  int          fails = 0;
  logic        saw_stall = 1'b0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PADHI = 64'h8000_0000_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic exp_fill(input int n, input int ones_upto);
    for (int i = 0; i < n; i++) stage[i] = (i < ones_upto) ? ONES : 64'h0;
  endtask

  task automatic exp_push(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.f = (i % 25 == 0);
      e.d = stage[i];
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic f, input logic l);
    int n;
    pushin = 1'b1; din = b; firstin = f; lastin = l;
    n = 0;
    while (stopin && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL send_timeout actual=stopin_stuck required=accept");
    end
    @(negedge clk); #1;
    pushin = 1'b0; firstin = 1'b0; lastin = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || pushout) && n < 3000) begin
      @(negedge clk); #3;
      n++;
    end
    chk(nm, 64'(q.size()), 64'h0);
  endtask

  initial begin : monitor
    exp_t        e;
    logic        hold_v;
    logic [63:0] hd;
    logic        hf;
    hold_v = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (hold_v) begin
        chk("hold_pushout", 64'(pushout), 64'h1);
        chk("hold_dout", dout, hd);
        chk("hold_firstout", 64'(firstout), 64'(hf));
      end
      if (stopout && stopin) saw_stall = 1'b1;
      if (pushout && stopout) begin
        hold_v = 1'b1; hd = dout; hf = firstout;
      end else begin
        hold_v = 1'b0;
      end
      if (pushout && !stopout) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_lane actual=%h required=no_lane", dout);
        end else begin
          e = q.pop_front();
          chk("lane_data", dout, e.d);
          chk("lane_firstout", 64'(firstout), 64'(e.f));
        end
      end
    end
  end

  task automatic one_byte_msg();
    exp_fill(25, 0);
    stage[0]  = 64'h0000_0000_0000_0661;
    stage[16] = PADHI;
    exp_push(25);
    send(8'h61, 1'b1, 1'b1);
    wait_drain("drain_1byte");
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pushout"}, 64'(pushout), 64'h0);
    chk({tag, "_firstout"}, 64'(firstout), 64'h0);
    chk({tag, "_dout"}, dout, 64'h0);
    chk({tag, "_stopin"}, 64'(stopin), 64'h1);
    chk({tag, "_err"}, 64'(err), 64'h0);
  endtask

  initial begin : stim
    rst = 1'b0; pushin = 1'b0; firstin = 1'b0; lastin = 1'b0; din = 8'h00; stopout = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;
    chk("stopin_before_first_edge", 64'(stopin), 64'h1);

    one_byte_msg();

    // 10 bytes 01..0A checks little-endian packing across a lane boundary
    exp_fill(25, 0);
    stage[0]  = 64'h0807_0605_0403_0201;
    stage[1]  = 64'h0000_0000_0006_0A09;
    stage[16] = PADHI;
    exp_push(25);
    for (int i = 0; i < 10; i++) send(8'(i + 1), i == 0, i == 9);
    wait_drain("drain_10byte");

    // 135 bytes: domain byte lands on the final rate byte
    exp_fill(25, 0);
    stage[16] = 64'h8600_0000_0000_0000;
    exp_push(25);
    for (int i = 0; i < 135; i++) send(8'h00, i == 0, i == 134);
    wait_drain("drain_135byte");

    // 136 bytes: exact rate boundary, padding fills a second block
    exp_fill(50, 17);
    stage[25] = 64'h0000_0000_0000_0006;
    stage[41] = PADHI;
    exp_push(50);
    for (int i = 0; i < 136; i++) send(8'hFF, i == 0, i == 135);
    wait_drain("drain_136byte");

    // output stall for 10 cycles after first pushout
    exp_fill(25, 0);
    stage[0]  = 64'h1716_1514_1312_1110;
    stage[1]  = 64'h1F1E_1D1C_1B1A_1918;
    stage[2]  = 64'h0000_0006_2322_2120;
    stage[16] = PADHI;
    exp_push(25);
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(8'(8'h10 + i), i == 0, i == 19);
      end
      begin
        int n;
        n = 0;
        while (!pushout && n < 200) begin
          @(negedge clk);
          n++;
        end
        stopout = 1'b1;
        repeat (10) @(negedge clk);
        stopout = 1'b0;
      end
    join
    wait_drain("drain_stall");
    chk("stopin_during_stall", 64'(saw_stall), 64'h1);

    // reset at byte 3 of lane 5
    exp_fill(5, 5);
    for (int i = 0; i < 5; i++) stage[i] = 64'hA5A5_A5A5_A5A5_A5A5;
    exp_push(5);
    for (int i = 0; i < 43; i++) send(8'hA5, i == 0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset_drained", 64'(q.size()), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("midreset");
    rst = 1'b1;
    chk("stopin_after_midreset", 64'(stopin), 64'h1);
    repeat (5) @(negedge clk);
    #1;
    chk("no_lane_after_reset", 64'(pushout), 64'h0);
    one_byte_msg();

    // firstin inside a message is treated as data; err only with the check enabled
    exp_fill(25, 0);
    stage[0]  = 64'h0000_0000_0603_0201;
    stage[16] = PADHI;
    exp_push(25);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0);
    send(8'h03, 1'b0, 1'b1);
    wait_drain("drain_err_msg");
`ifdef KECCAK_PAD_PROTO_CHECK_EN
    chk("err_set", 64'(err), 64'h1);
    repeat (5) @(negedge clk);
    #1;
    chk("err_sticky", 64'(err), 64'h1);
`else
    chk("err_tied_low", 64'(err), 64'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("err_cleared_by_reset", 64'(err), 64'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
